// File: rtl/tank_sprite_render_if.sv
// Object update port between game logic and the tank sprite renderer.
// master drives position/direction/enable requests; slave returns upd_ready.
interface tank_sprite_render_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [1:0] upd_id;
  logic [9:0] upd_x;
  logic [9:0] upd_y;
  logic [1:0] upd_dir;
  logic       upd_en;

  modport master (
    output upd_valid, upd_id, upd_x,
    output upd_y, upd_dir, upd_en,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_id, upd_x,
    input  upd_y, upd_dir, upd_en,
    output upd_ready
  );
endinterface

// File: rtl/tank_sprite_render.sv
// Renders 2 ROM-backed 32x32 tank sprites and 2 solid bullets over a flat
// background, 3-cycle latency for colour and syncs.
// Ports: clk, RSTN (async, active-high), pixel_x/y + syncs from the timing
// generator, upd (slave modport) object updates, rom_addr/rom_data sprite
// ROM, rgb/hsync_out/vsync_out to the DAC, frame_start on commit.
module tank_sprite_render #(
  parameter int          H_VISIBLE    = 640,
  parameter int          V_VISIBLE    = 480,
  parameter int          TANK_SIZE    = 32,
  parameter int          BULLET_SIZE  = 4,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BULLET_COLOR = 12'hFF0,
  parameter logic [11:0] TRANS_COLOR  = 12'hF0F
) (
  input  logic                        clk,
  input  logic                        RSTN,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  tank_sprite_render_if.slave         upd,
  output logic [12:0]                 rom_addr,
  input  logic [11:0]                 rom_data,
  output logic [11:0]                 rgb,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        frame_start
);

  logic [9:0] sh_x_q [4];
  logic [9:0] sh_y_q [4];
  logic [1:0] sh_d_q [4];
  logic [3:0] sh_en_q;
  logic [9:0] ac_x_q [4];
  logic [9:0] ac_y_q [4];
  logic [1:0] ac_d_q [4];
  logic [3:0] ac_en_q;

  logic vs_q, rdy_q;
  logic commit, acc;

  // Commit on vsync falling edge; the port stalls
  // for that one cycle so shadow and active never race.
  assign commit        = vs_q & ~vsync_in;
  assign upd.upd_ready = rdy_q & ~commit;
  assign acc           = upd.upd_valid & upd.upd_ready;
  assign frame_start   = commit;

  always_ff @(posedge clk or posedge RSTN) begin
    if (RSTN) begin
      vs_q    <= 1'b0;
      rdy_q   <= 1'b0;
      sh_en_q <= '0;
      ac_en_q <= '0;
      for (int i = 0; i < 4; i++) begin
        sh_x_q[i] <= '0;
        sh_y_q[i] <= '0;
        sh_d_q[i] <= '0;
        ac_x_q[i] <= '0;
        ac_y_q[i] <= '0;
        ac_d_q[i] <= '0;
      end
    end else begin
      vs_q  <= vsync_in;
      rdy_q <= 1'b1;
      if (acc) begin
        sh_x_q[upd.upd_id]  <= upd.upd_x;
        sh_y_q[upd.upd_id]  <= upd.upd_y;
        sh_d_q[upd.upd_id]  <= upd.upd_dir;
        sh_en_q[upd.upd_id] <= upd.upd_en;
      end
      if (commit) begin
        ac_en_q <= sh_en_q;
        for (int i = 0; i < 4; i++) begin
          ac_x_q[i] <= sh_x_q[i];
          ac_y_q[i] <= sh_y_q[i];
          ac_d_q[i] <= sh_d_q[i];
        end
      end
    end
  end

  // Wrapping 10-bit offsets: a single unsigned compare
  // clips objects that hang off any screen edge.
  logic [9:0]  dx [4];
  logic [9:0]  dy [4];
  logic [3:0]  hit;
  logic        vis_d;
  logic [12:0] rom_addr_d;

  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      dx[i] = pixel_x - ac_x_q[i];
      dy[i] = pixel_y - ac_y_q[i];
      if (i < 2)
        hit[i] = ac_en_q[i]
               && dx[i] < 10'(TANK_SIZE)
               && dy[i] < 10'(TANK_SIZE);
      else
        hit[i] = ac_en_q[i]
               && dx[i] < 10'(BULLET_SIZE)
               && dy[i] < 10'(BULLET_SIZE);
    end
    vis_d = pixel_x < 10'(H_VISIBLE)
         && pixel_y < 10'(V_VISIBLE);
  end

  always_comb begin
    rom_addr_d = '0;
    if (hit[0])
      rom_addr_d = {1'b0, ac_d_q[0],
                    dy[0][4:0], dx[0][4:0]};
    else if (hit[1])
      rom_addr_d = {1'b1, ac_d_q[1],
                    dy[1][4:0], dx[1][4:0]};
  end

  logic        vis1_q, bul1_q, tnk1_q, hs1_q, vs1_q;
  logic        vis2_q, bul2_q, tnk2_q, hs2_q, vs2_q;
  logic [12:0] rom_addr_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hso_q, vso_q;

  // Transparent tank0 pixels fall to background, never to tank1.
  always_comb begin
    rgb_d = BG_COLOR;
    if (!vis2_q)
      rgb_d = 12'h000;
    else if (bul2_q)
      rgb_d = BULLET_COLOR;
    else if (tnk2_q && rom_data != TRANS_COLOR)
      rgb_d = rom_data;
  end

  always_ff @(posedge clk or posedge RSTN) begin
    if (RSTN) begin
      rom_addr_q <= '0;
      vis1_q <= 1'b0; bul1_q <= 1'b0; tnk1_q <= 1'b0;
      hs1_q  <= 1'b0; vs1_q  <= 1'b0;
      vis2_q <= 1'b0; bul2_q <= 1'b0; tnk2_q <= 1'b0;
      hs2_q  <= 1'b0; vs2_q  <= 1'b0;
      rgb_q  <= '0;
      hso_q  <= 1'b0;
      vso_q  <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      vis1_q <= vis_d;
      bul1_q <= hit[2] | hit[3];
      tnk1_q <= hit[0] | hit[1];
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      vis2_q <= vis1_q;
      bul2_q <= bul1_q;
      tnk2_q <= tnk1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      rgb_q  <= rgb_d;
      hso_q  <= hs2_q;
      vso_q  <= vs2_q;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rgb       = rgb_q;
  assign hsync_out = hso_q;
  assign vsync_out = vso_q;

endmodule

// File: tb/tb_tank_sprite_render.sv
// Randomized + directed bench for tank_sprite_render against a
// frame-level behavioural model with a stub ROM returning addr[11:0].
module tb_tank_sprite_render;
  logic        clk = 1'b0;
  logic        RSTN;
  logic [9:0]  pixel_x, pixel_y;
  logic        hsync_in, vsync_in;
  logic [12:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_start;

  tank_sprite_render_if upd();

  tank_sprite_render dut (
    .clk(clk), .RSTN(RSTN),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .upd(upd),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Stub ROM: column 0 of every sprite is transparent.
  always @(posedge clk)
    rom_data <= (rom_addr[4:0] == 5'd0) ? 12'hF0F
                                        : rom_addr[11:0];

  int n_cmp = 0;
  int n_bad = 0;
  int sx[4], sy[4], sd[4], se[4];
  int ax[4], ay[4], ad[4], ae[4];
  bit mready, mvsp;
  logic [13:0] q[$];
  int cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int wrapd(input int a, input int b);
    return (a - b + 1024) % 1024;
  endfunction

  function automatic void model_pix(input int px, input int py,
                                    output logic [11:0] col,
                                    output logic [12:0] ra);
    bit vis, bul;
    int t, r, c, v;
    vis = px < 640 && py < 480;
    bul = 0; t = -1; r = 0; c = 0; v = 0;
    ra = '0;
    for (int k = 2; k < 4; k++)
      if (ae[k] != 0 && wrapd(px, ax[k]) < 4
          && wrapd(py, ay[k]) < 4) bul = 1;
    for (int k = 1; k >= 0; k--)
      if (ae[k] != 0 && wrapd(px, ax[k]) < 32
          && wrapd(py, ay[k]) < 32) t = k;
    if (t >= 0) begin
      r = wrapd(py, ay[t]);
      c = wrapd(px, ax[t]);
      ra = 13'(t * 4096 + ad[t] * 1024 + r * 32 + c);
      v = (c == 0) ? 'hF0F : ad[t] * 1024 + r * 32 + c;
    end
    if (!vis) col = 12'h000;
    else if (bul) col = 12'hFF0;
    else if (t >= 0 && v != 'hF0F) col = 12'(v);
    else col = 12'h000;
  endfunction

  task automatic step();
    logic [11:0] ec;
    logic [12:0] ea;
    logic [13:0] e;
    bit cm, rdy, acc;
    int id;
    #1;
    cm  = mvsp && !vsync_in;
    rdy = mready && !cm;
    chk("upd_ready", upd.upd_ready, rdy);
    chk("frame_start", frame_start, cm);
    model_pix(int'(pixel_x), int'(pixel_y), ec, ea);
    q.push_back({hsync_in, vsync_in, ec});
    acc = upd.upd_valid && rdy;
    id  = int'(upd.upd_id);
    @(posedge clk);
    if (acc) begin
      sx[id] = int'(upd.upd_x);
      sy[id] = int'(upd.upd_y);
      sd[id] = int'(upd.upd_dir);
      se[id] = int'(upd.upd_en);
    end
    if (cm) begin
      ax = sx; ay = sy; ad = sd; ae = se;
    end
    mvsp   = vsync_in;
    mready = 1;
    #1;
    chk("rom_addr", rom_addr, ea);
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("rgb", rgb, e[11:0]);
      chk("hsync_out", hsync_out, e[13]);
      chk("vsync_out", vsync_out, e[12]);
    end
  endtask

  task automatic do_reset();
    RSTN = 1'b1;
    #2;
    chk("rst_rgb", rgb, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_hsync", hsync_out, 0);
    chk("rst_vsync", vsync_out, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_ready", upd.upd_ready, 0);
    for (int k = 0; k < 4; k++) begin
      sx[k] = 0; sy[k] = 0; sd[k] = 0; se[k] = 0;
      ax[k] = 0; ay[k] = 0; ad[k] = 0; ae[k] = 0;
    end
    mready = 0;
    mvsp   = 0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_rgb", rgb, 0);
    chk("rst_hold_ready", upd.upd_ready, 0);
    @(negedge clk);
    RSTN = 1'b0;
    q.push_back('0);
    q.push_back('0);
  endtask

  task automatic wr(input int id, input int x, input int y,
                    input int d, input int en);
    bit ok;
    ok = 0;
    upd.upd_valid = 1'b1;
    upd.upd_id    = 2'(id);
    upd.upd_x     = 10'(x);
    upd.upd_y     = 10'(y);
    upd.upd_dir   = 2'(d);
    upd.upd_en    = 1'(en);
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = mready && !(mvsp && !vsync_in);
      step();
    end
    if (!ok) chk("wr_timeout", 0, 1);
    upd.upd_valid = 1'b0;
  endtask

  task automatic scan(input int x0, input int x1, input int y);
    for (int x = x0; x <= x1; x++) begin
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      hsync_in = 1'($urandom);
      step();
    end
  endtask

  task automatic vfall();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
  endtask

  task automatic rnd(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      cnt++;
      vsync_in = (cnt % 37) >= 4;
      hsync_in = 1'($urandom);
      if ($urandom % 4 == 0) begin
        pixel_x = 10'($urandom);
        pixel_y = 10'($urandom);
      end else begin
        k = $urandom % 4;
        pixel_x = 10'(ax[k] + int'($urandom % 40) - 4);
        pixel_y = 10'(ay[k] + int'($urandom % 40) - 4);
      end
      upd.upd_valid = ($urandom % 4 == 0);
      upd.upd_id    = 2'($urandom);
      upd.upd_dir   = 2'($urandom);
      upd.upd_en    = ($urandom % 4 != 0);
      case ($urandom % 3)
        0: upd.upd_x = 10'($urandom);
        1: upd.upd_x = 10'(600 + $urandom % 40);
        default: upd.upd_x = 10'(990 + $urandom % 34);
      endcase
      case ($urandom % 3)
        0: upd.upd_y = 10'($urandom);
        1: upd.upd_y = 10'(440 + $urandom % 40);
        default: upd.upd_y = 10'(1000 + $urandom % 24);
      endcase
      step();
    end
    upd.upd_valid = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0;
    pixel_x = '0; pixel_y = '0;
    hsync_in = 1'b0; vsync_in = 1'b1;
    upd.upd_valid = 1'b0; upd.upd_id = '0;
    upd.upd_x = '0; upd.upd_y = '0;
    upd.upd_dir = '0; upd.upd_en = 1'b0;
    #1;
    do_reset();

    scan(0, 40, 10);
    scan(630, 645, 479);
    wr(0, 100, 50, 1, 1);
    wr(2, 110, 60, 0, 1);
    wr(1, 630, 470, 2, 1);
    scan(96, 104, 50);
    vfall();
    scan(96, 136, 50);
    scan(96, 136, 60);
    scan(96, 136, 63);
    scan(96, 136, 81);
    scan(96, 136, 82);
    scan(626, 645, 469);
    scan(626, 645, 470);
    scan(626, 645, 479);
    scan(626, 645, 480);
    scan(1018, 1023, 470);

    // Request held across the commit cycle.
    upd.upd_valid = 1'b1;
    upd.upd_id    = 2'd0;
    upd.upd_x     = 10'd200;
    upd.upd_y     = 10'd100;
    upd.upd_dir   = 2'd3;
    upd.upd_en    = 1'b1;
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
    upd.upd_valid = 1'b0;
    scan(98, 104, 55);
    vfall();
    scan(98, 104, 55);
    scan(196, 234, 124);

    pixel_x = 10'd210;
    pixel_y = 10'd110;
    step();
    do_reset();
    scan(196, 234, 110);
    vfall();
    scan(196, 234, 110);
    wr(0, 200, 100, 3, 1);
    vfall();
    scan(196, 234, 110);

    rnd(3000);
    do_reset();
    rnd(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
